// File: rtl/mem_write_controller_pkg.sv
// Shared store-side constants: opcodes, store widths, MMIO offsets.
// Read and write controllers both import this to share one address map.
package mem_write_controller_pkg;

  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;

  localparam logic [2:0] FNC_SB = 3'b000;
  localparam logic [2:0] FNC_SH = 3'b001;
  localparam logic [2:0] FNC_SW = 3'b010;

  localparam logic [3:0] IO_REGION  = 4'b1000;
  localparam logic [7:0] IO_UART_TX = 8'h08;
  localparam logic [7:0] IO_CNT_CLR = 8'h18;
  localparam logic [7:0] IO_LED     = 8'h30;
  localparam logic [7:0] IO_AC_DIN  = 8'h44;

  typedef struct packed {
    logic uart;
    logic clr;
    logic led;
    logic ac;
  } io_hit_t;

endpackage

// File: rtl/mem_write_controller_store_lane_align.sv
// Store lane aligner: funct3 + addr[1:0] + rs2 -> byte enables, data.
// Ports: funct3, offset, rs2 in; be, wdata out. Purely combinational.
module store_lane_align
  import mem_write_controller_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rs2,
  output logic [3:0]  be,
  output logic [31:0] wdata
);

  always_comb begin
    be    = 4'b0000;
    wdata = 32'h0;
    case (funct3)
      FNC_SB: begin
        be    = 4'b0001 << offset;
        wdata = {4{rs2[7:0]}};
      end
      FNC_SH: begin
        unique case (offset)
          2'd1: begin
            be    = 4'b0110;
            wdata = {8'h0, rs2[15:0], 8'h0};
          end
          2'd2: begin
            be    = 4'b1100;
            wdata = {rs2[15:0], 16'h0};
          end
          // offset 3 folds to 0, same as the load side
          default: begin
            be    = 4'b0011;
            wdata = {16'h0, rs2[15:0]};
          end
        endcase
      end
      FNC_SW: begin
        be    = 4'b1111;
        wdata = rs2;
      end
      default: begin
        be    = 4'b0000;
        wdata = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/mem_write_controller.sv
// Memory-stage store controller: DMEM/IMEM byte enables and MMIO writes.
// Ports: store inputs (instruction/valid/addr/data/pc), UART, counters,
// LEDs, audio FIFO push, and stall back to the pipeline.
module mem_write_controller
  import mem_write_controller_pkg::*;
#(
  parameter int LED_WIDTH = 6,
  parameter int AC_WIDTH  = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instruction,
  input  logic                 valid,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          store_data,
  input  logic [31:0]          pc,
  input  logic                 instr_retire,
  input  logic                 uart_tx_ready,
  input  logic                 ac_fifo_full,
  output logic [3:0]           dmem_we,
  output logic [3:0]           imem_we,
  output logic [31:0]          mem_wdata,
  output logic                 uart_tx_valid,
  output logic [7:0]           uart_tx_data,
  output logic [31:0]          cycle_counter,
  output logic [31:0]          instret_counter,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 ac_fifo_wr_en,
  output logic [AC_WIDTH-1:0]  ac_fifo_din,
  output logic                 stall
);

  logic                 is_store;
  logic                 go;
  logic                 in_dmem;
  logic                 in_imem;
  logic                 in_io;
  logic [7:0]           io_off;
  io_hit_t              hit;
  logic [3:0]           be;
  logic [31:0]          lane_wdata;
  logic                 uart_busy;
  logic [31:0]          cycle_q;
  logic [31:0]          cycle_nxt;
  logic [31:0]          instret_q;
  logic [31:0]          instret_nxt;
  logic                 uart_vld_q;
  logic [7:0]           uart_dat_q;
  logic [LED_WIDTH-1:0] leds_q;
  logic                 unused_ok;

  assign unused_ok = ^{instruction[31:15], instruction[11:7],
                       mem_addr[27:8], pc[31], pc[29:0]};

  store_lane_align u_align (
    .funct3 (instruction[14:12]),
    .offset (mem_addr[1:0]),
    .rs2    (store_data),
    .be     (be),
    .wdata  (lane_wdata)
  );

  assign is_store = valid && (instruction[6:0] == OPC_STORE);
  assign in_dmem  = (mem_addr[31:30] == 2'b00) && mem_addr[28];
  assign in_imem  = (mem_addr[31:29] == 3'b001) && pc[30];
  assign in_io    = (mem_addr[31:28] == IO_REGION);
  assign io_off   = mem_addr[7:0];

  always_comb begin
    hit = '0;
    if (is_store && in_io) begin
      unique case (1'b1)
        io_off == IO_UART_TX: hit.uart = 1'b1;
        io_off == IO_CNT_CLR: hit.clr  = 1'b1;
        io_off == IO_LED:     hit.led  = 1'b1;
        io_off == IO_AC_DIN:  hit.ac   = 1'b1;
        default: hit = '0;
      endcase
    end
  end

  // Holder is free when empty or when it drains this very cycle.
  assign uart_busy = uart_vld_q && !uart_tx_ready;

  assign stall = (hit.uart && uart_busy) ||
                 (hit.ac && ac_fifo_full);
  assign go    = is_store && !stall;

  assign dmem_we   = (go && in_dmem) ? be : 4'b0000;
  assign imem_we   = (go && in_imem) ? be : 4'b0000;
  assign mem_wdata = is_store ? lane_wdata : 32'h0;

  assign ac_fifo_wr_en = hit.ac && !ac_fifo_full;
  assign ac_fifo_din   = ac_fifo_wr_en ?
                         store_data[AC_WIDTH-1:0] : '0;

  // Clear beats both the free-running increment and retire.
  assign cycle_nxt   = hit.clr ? 32'h0 : cycle_q + 32'd1;
  assign instret_nxt = hit.clr ? 32'h0 :
                       instret_q + {31'h0, instr_retire};

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q    <= 32'h0;
      instret_q  <= 32'h0;
      uart_vld_q <= 1'b0;
      uart_dat_q <= 8'h0;
      leds_q     <= '0;
    end else begin
      cycle_q   <= cycle_nxt;
      instret_q <= instret_nxt;
      if (hit.uart && !stall) begin
        uart_vld_q <= 1'b1;
        uart_dat_q <= store_data[7:0];
      end else if (uart_tx_ready) begin
        uart_vld_q <= 1'b0;
      end
      if (hit.led) begin
        leds_q <= store_data[LED_WIDTH-1:0];
      end
    end
  end

  assign cycle_counter   = cycle_q;
  assign instret_counter = instret_q;
  assign uart_tx_valid   = uart_vld_q;
  assign uart_tx_data    = uart_dat_q;
  assign leds            = leds_q;

endmodule

// File: doc/mem_write_controller.md
Name: mem_write_controller

Overview:
Store-side counterpart of the load path. Decodes committed store instructions in the memory stage. Drives DMEM/IMEM byte write enables and shifted write data. Owns the write-side MMIO state: UART transmit holding register and handshake, cycle and instret counters, LED register, and audio-FIFO write strobe. Raises a stall when an MMIO target cannot accept the store.

Parameters:
LED_WIDTH, 6, width of LED register
AC_WIDTH, 20, width of audio FIFO sample word

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
instruction  input  32  memory-stage instruction
valid  input  1  memory-stage instruction is live (not flushed/bubble)
mem_addr  input  32  effective address (ALU result)
store_data  input  32  rs2 value
pc  input  32  memory-stage PC (bit 30 = running from BIOS)
instr_retire  input  1  one instruction retires this cycle
uart_tx_ready  input  1  UART transmitter accepts byte
ac_fifo_full  input  1  audio FIFO full
dmem_we  output  4  DMEM byte enables
imem_we  output  4  IMEM byte enables
mem_wdata  output  32  lane-shifted store data (DMEM and IMEM)
uart_tx_valid  output  1  transmit byte valid
uart_tx_data  output  8  transmit byte
cycle_counter  output  32  cycles since reset/clear (read side: 0x8000_0010)
instret_counter  output  32  retired instructions (read side: 0x8000_0014)
leds  output  LED_WIDTH  LED register
ac_fifo_wr_en  output  1  audio FIFO push
ac_fifo_din  output  AC_WIDTH  audio sample
stall  output  1  hold memory stage

Behaviour:
- is_store = valid && opcode==OPC_STORE. All side effects are qualified by is_store && !stall.
- Lane logic is combinational and applies to the same cycle. The memories register it.
  - SB: be = 4'b0001<<addr[1:0]; data = {4{rs2[7:0]}}.
  - SH: offset 00 -> be 0011; 01 -> 0110; 10 -> 1100; 11 -> 0011 (offset zeroed, matching load side). Data is rs2[15:0] shifted by 8*offset (11 -> unshifted).
  - SW: be = 1111, offset ignored.
  - Unknown funct3: be = 0, plus $display.
- Region decode on addr[31:28]:
  - 4'b00X1 -> dmem_we = be.
  - 4'b001X and pc[30]==1 -> imem_we = be.
  - 4'b1000 -> IO on addr[7:0].
  - Anything else drives no enable.
  - 4'b0011 with pc[30]==1 writes both DMEM and IMEM.
- IO 0x08 UART TX:
  - If !uart_tx_valid, or uart_tx_valid && uart_tx_ready, latch store_data[7:0]; uart_tx_valid=1 next cycle.
  - Otherwise stall=1 (combinational). The pipeline re-presents the store each cycle until the handshake frees the holder. Back-to-back accept happens on the handshake cycle.
  - uart_tx_valid clears the cycle after valid&&ready when no new byte is latched.
  - uart_tx_data is stable while valid.
- IO 0x18: clears both counters next cycle. The clear wins over increment and over instr_retire.
- Counters:
  - cycle_counter +1 every cycle.
  - instret_counter +1 when instr_retire.
  - Both wrap modulo 2^32.
- IO 0x30: leds <= store_data[LED_WIDTH-1:0] next cycle.
- IO 0x44:
  - If !ac_fifo_full: ac_fifo_wr_en=1 same cycle, ac_fifo_din=store_data[AC_WIDTH-1:0].
  - Else stall=1 and wr_en=0.
- Other IO offsets: no effect, $display.
- stall is only ever asserted for a live store to 0x08 or 0x44. It is never asserted for loads.
- Reset values:
  - Counters 0, uart_tx_valid 0, uart_tx_data 0, leds 0.
  - Combinational outputs are 0 when no store.
  - Reset mid-handshake drops the pending byte.

Decomposition:
- Shared opcode/funct3 defines: OPC_STORE, FNC_SB/SH/SW.
- Add MMIO offset constants to the shared constants header so the read and write controllers use one address map: IO_UART_TX=8'h08, IO_CNT_CLR=8'h18, IO_LED=8'h30, IO_AC_DIN=8'h44.
- One natural sub-module, store_lane_align: funct3 + addr[1:0] + rs2 -> be, wdata. Combinational, reusable.

Test Plan:
1. SB to 0x1000_0003, rs2=0x0000_00A5 -> dmem_we=1000, mem_wdata=0xA5A5_A5A5, imem_we=0.
2. SH to 0x2000_0001 with pc=0x4000_0000 -> imem_we=0110, mem_wdata[23:8]=rs2[15:0]. Same store with pc=0x1000_0000 -> imem_we=0000.
3. Two SW to 0x8000_0008 (0x41, 0x42), uart_tx_ready low 3 cycles then high:
   - uart_tx_valid=1 with data 0x41.
   - Second store stalls 3 cycles and is accepted on the ready cycle.
   - Data becomes 0x42 next cycle; valid drops after the second handshake.
4. Run 100 cycles with 40 retires, then SW to 0x8000_0018 with instr_retire high -> both counters read 0 next cycle, then 1 and 0/1 as stimulus continues. Preload cycle_counter 0xFFFF_FFFF -> wraps to 0.
5. SW to 0x8000_0044 with ac_fifo_full=1 for 2 cycles -> stall=1, wr_en=0. Full drops -> wr_en=1 with ac_fifo_din=store_data[19:0], stall=0.
6. SW to 0x8000_0030 of 0x3F, then rst=1 -> leds=0x3F, then 0. Store with valid=0 -> no enables.
